// File: rtl/deco_exe_ctrl_stage.sv
// Decode-to-execute control stage.
// Registers one control word from decode behind a valid/ready handshake.
// Stalls trig (SIN/COS) instructions for TRIG_LATENCY cycles.
// Retires instructions toward the memory stage.
// On retire it commits NZCV flags, raises branch redirects and counts instructions.
//
// in_ctrl / out_ctrl packing (MSB..LSB):
//   [15] pcSrc  [14] regWrite  [13] trigControl  [12:9] aluControl
//   [8:7] memToReg  [6] flagWrite  [5] immSrc  [4] aluSrc
//   [3] memWrite  [2] memPixWrite  [1] branch  [0] bLink
module deco_exe_ctrl_stage #(
  parameter int TRIG_LATENCY = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_ctrl,
  input  logic [3:0]       alu_flags,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_ctrl,
  output logic [3:0]       flags,
  output logic             redirect,
  output logic             link_write,
  output logic [CNT_W-1:0] retired_count
);

  localparam int          BIT_PCSRC  = 15;
  localparam int          BIT_TRIG   = 13;
  localparam int          BIT_FLAGW  = 6;
  localparam int          BIT_BRANCH = 1;
  localparam int          BIT_BLINK  = 0;

  // A latency of 1 means trig instructions behave like any other.
  localparam bit          TRIG_STALL = (TRIG_LATENCY > 1);
  localparam int          TC_W       = $clog2(TRIG_LATENCY + 1);
  localparam int          TRIG_LOAD_I = TRIG_STALL ? (TRIG_LATENCY - 2) : 0;
  localparam logic [TC_W-1:0] TRIG_LOAD = TC_W'(TRIG_LOAD_I);

  typedef enum logic [1:0] {
    S_EMPTY     = 2'd0,
    S_TRIG_BUSY = 2'd1,
    S_HOLD      = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  state_t           w_cap_state;
  logic [15:0]      r_ctrl;
  logic [TC_W-1:0]  r_trig_cnt;
  logic [3:0]       r_flags;
  logic             r_redirect;
  logic             r_link_write;
  logic [CNT_W-1:0] r_retired;

  logic             w_out_valid;
  logic             w_in_ready;
  logic             w_fire;
  logic             w_take;
  logic             w_capture;
  logic             w_cap_trig;

  // Handshake decode and next-state selection; flush overrides everything.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_in_ready  = 1'b0;
    w_state_nxt = r_state;
    w_out_valid = (r_state == S_HOLD);
    w_fire      = w_out_valid & out_ready & ~flush;
    w_take      = w_fire & r_ctrl[BIT_PCSRC] & r_ctrl[BIT_BRANCH];
    w_cap_trig  = in_ctrl[BIT_TRIG] & TRIG_STALL;
    w_cap_state = w_cap_trig ? S_TRIG_BUSY : S_HOLD;

    case (r_state)
      S_EMPTY: w_in_ready = ~flush;
      S_HOLD:  w_in_ready = out_ready & ~flush;
      default: w_in_ready = 1'b0;
    endcase

    // A word accepted alongside a taken branch is on the wrong path: squash it.
    w_capture = in_valid & w_in_ready & ~w_take;

    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_capture) w_state_nxt = w_cap_state;
        end
        S_TRIG_BUSY: begin
          if (r_trig_cnt == '0) w_state_nxt = S_HOLD;
        end
        S_HOLD: begin
          if (w_fire) w_state_nxt = w_capture ? w_cap_state : S_EMPTY;
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // State register and held control word.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      r_state <= S_EMPTY;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) r_ctrl <= in_ctrl;
    end
  end

  // Trig stall counter: loaded on capture of a trig word, counts down while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trig_cnt <= '0;
    end else if (w_capture && w_cap_trig) begin
      r_trig_cnt <= TRIG_LOAD;
    end else if (r_state == S_TRIG_BUSY && r_trig_cnt != '0) begin
      r_trig_cnt <= r_trig_cnt - TC_W'(1);
    end
  end

  // Retire side effects: flag commit, instruction count, one-cycle redirect pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags      <= '0;
      r_retired    <= '0;
      r_redirect   <= 1'b0;
      r_link_write <= 1'b0;
    end else begin
      if (w_fire && r_ctrl[BIT_FLAGW]) r_flags <= alu_flags;
      if (w_fire) r_retired <= r_retired + CNT_W'(1);
      r_redirect   <= w_take;
      r_link_write <= w_take & r_ctrl[BIT_BLINK];
    end
  end

  assign in_ready      = w_in_ready;
  assign out_valid     = w_out_valid;
  assign out_ctrl      = r_ctrl;
  assign flags         = r_flags;
  assign redirect      = r_redirect;
  assign link_write    = r_link_write;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_deco_exe_ctrl_stage.sv
// Directed bench for deco_exe_ctrl_stage.
// Uses a vector table for single-cycle behaviour plus hand-written multi-cycle sequences.
module tb_deco_exe_ctrl_stage;

  localparam int TRIG_LATENCY = 4;
  localparam int CNT_W        = 4;

  localparam logic [15:0] C_NOP  = 16'h0000;
  localparam logic [15:0] C_ADD  = 16'h4480; // regWrite, alu 0010, memToReg 01
  localparam logic [15:0] C_CMP  = 16'h0240; // flagWrite, alu 0001
  localparam logic [15:0] C_SIN  = 16'h6000; // regWrite, trigControl
  localparam logic [15:0] C_BL   = 16'h8003; // pcSrc, branch, bLink
  localparam logic [15:0] C_B    = 16'h8002; // pcSrc, branch
  localparam logic [15:0] C_BNT  = 16'h0002; // branch not taken

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_ctrl;
  logic [3:0]       alu_flags;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_ctrl;
  logic [3:0]       flags;
  logic             redirect;
  logic             link_write;
  logic [CNT_W-1:0] retired_count;

  int n_total = 0;
  int n_bad   = 0;

  deco_exe_ctrl_stage #(.TRIG_LATENCY(TRIG_LATENCY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .alu_flags(alu_flags), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .flags(flags), .redirect(redirect), .link_write(link_write),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] ctrl;
    logic [3:0]  af;
    logic        fl;
    logic        ordy;
    logic        e_ir;    // before the edge
    logic        e_ov;    // before the edge
    logic [15:0] e_oc;    // before the edge, compared only when e_ov
    logic [3:0]  e_flags; // after the edge
    logic        e_redir; // after the edge
    logic        e_link;  // after the edge
    logic [3:0]  e_cnt;   // after the edge
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] c, input logic [3:0] af,
                       input logic fl, input logic ordy);
    in_valid  = v;
    in_ctrl   = c;
    alu_flags = af;
    flush     = fl;
    out_ready = ordy;
  endtask

  function automatic vec_t mk(input logic v, input logic [15:0] c, input logic [3:0] af,
                              input logic fl, input logic ordy, input logic ir, input logic ov,
                              input logic [15:0] oc, input logic [3:0] f, input logic rd,
                              input logic lk, input logic [3:0] cnt);
    vec_t r;
    r.v = v; r.ctrl = c; r.af = af; r.fl = fl; r.ordy = ordy;
    r.e_ir = ir; r.e_ov = ov; r.e_oc = oc; r.e_flags = f;
    r.e_redir = rd; r.e_link = lk; r.e_cnt = cnt;
    return r;
  endfunction

  initial begin
    //            v     ctrl   af    fl    ordy  ir    ov    oc     flags rd    lk    cnt
    vecs[0]  = mk(1'b1, C_ADD, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, C_NOP, 4'h0, 1'b0, 1'b0, 4'd0);
    vecs[1]  = mk(1'b0, C_NOP, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, C_ADD, 4'h0, 1'b0, 1'b0, 4'd1);
    vecs[2]  = mk(1'b1, C_CMP, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, C_NOP, 4'h0, 1'b0, 1'b0, 4'd1);
    vecs[3]  = mk(1'b1, C_ADD, 4'h4, 1'b0, 1'b1, 1'b1, 1'b1, C_CMP, 4'h4, 1'b0, 1'b0, 4'd2);
    vecs[4]  = mk(1'b0, C_NOP, 4'hA, 1'b0, 1'b1, 1'b1, 1'b1, C_ADD, 4'h4, 1'b0, 1'b0, 4'd3);
    vecs[5]  = mk(1'b1, C_CMP, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, C_NOP, 4'h4, 1'b0, 1'b0, 4'd3);
    vecs[6]  = mk(1'b1, C_ADD, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, C_CMP, 4'h4, 1'b0, 1'b0, 4'd3);
    vecs[7]  = mk(1'b1, C_ADD, 4'h8, 1'b0, 1'b1, 1'b1, 1'b1, C_CMP, 4'h8, 1'b0, 1'b0, 4'd4);
    vecs[8]  = mk(1'b1, C_BL,  4'h0, 1'b0, 1'b1, 1'b1, 1'b1, C_ADD, 4'h8, 1'b0, 1'b0, 4'd5);
    vecs[9]  = mk(1'b1, C_ADD, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, C_BL,  4'h8, 1'b1, 1'b1, 4'd6);
    vecs[10] = mk(1'b0, C_NOP, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, C_NOP, 4'h8, 1'b0, 1'b0, 4'd6);
    vecs[11] = mk(1'b1, C_B,   4'h0, 1'b0, 1'b1, 1'b1, 1'b0, C_NOP, 4'h8, 1'b0, 1'b0, 4'd6);
    vecs[12] = mk(1'b0, C_NOP, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, C_B,   4'h8, 1'b1, 1'b0, 4'd7);
    vecs[13] = mk(1'b1, C_BNT, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, C_NOP, 4'h8, 1'b0, 1'b0, 4'd7);
    vecs[14] = mk(1'b1, C_CMP, 4'h1, 1'b0, 1'b1, 1'b1, 1'b1, C_BNT, 4'h8, 1'b0, 1'b0, 4'd8);
    vecs[15] = mk(1'b1, C_ADD, 4'h3, 1'b1, 1'b1, 1'b0, 1'b1, C_CMP, 4'h8, 1'b0, 1'b0, 4'd8);
    vecs[16] = mk(1'b0, C_NOP, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, C_NOP, 4'h8, 1'b0, 1'b0, 4'd8);
    vecs[17] = mk(1'b1, C_ADD, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, C_NOP, 4'h8, 1'b0, 1'b0, 4'd8);
    vecs[18] = mk(1'b0, C_NOP, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, C_NOP, 4'h8, 1'b0, 1'b0, 4'd8);

    rst = 1'b1;
    drive(1'b0, C_NOP, 4'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready",  32'(in_ready), 32'(1));
    check("rst_out_ctrl",  32'(out_ctrl), 32'(0));
    check("rst_flags",     32'(flags), 32'(0));
    check("rst_redirect",  32'(redirect), 32'(0));
    check("rst_count",     32'(retired_count), 32'(0));

    // Table-driven single-cycle behaviour.
    tick();
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].v, vecs[i].ctrl, vecs[i].af, vecs[i].fl, vecs[i].ordy);
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      if (vecs[i].e_ov)
        check($sformatf("v%0d_out_ctrl", i), 32'(out_ctrl), 32'(vecs[i].e_oc));
      tick();
      check($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].e_flags));
      check($sformatf("v%0d_redirect", i), 32'(redirect), 32'(vecs[i].e_redir));
      check($sformatf("v%0d_link_write", i), 32'(link_write), 32'(vecs[i].e_link));
      check($sformatf("v%0d_count", i), 32'(retired_count), 32'(vecs[i].e_cnt));
    end

    // Trig stall: SIN with in_valid held, next word waits, then captured on fire.
    drive(1'b1, C_SIN, 4'h0, 1'b0, 1'b1);
    #1;
    check("trig_cap_ready", 32'(in_ready), 32'(1));
    tick();
    in_ctrl = C_ADD;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("trig_busy%0d_ready", k), 32'(in_ready), 32'(0));
      check($sformatf("trig_busy%0d_valid", k), 32'(out_valid), 32'(0));
      tick();
    end
    #1;
    check("trig_done_valid", 32'(out_valid), 32'(1));
    check("trig_done_ctrl",  32'(out_ctrl), 32'(C_SIN));
    check("trig_done_ready", 32'(in_ready), 32'(1));
    tick();
    in_valid = 1'b0;
    check("trig_next_valid", 32'(out_valid), 32'(1));
    check("trig_next_ctrl",  32'(out_ctrl), 32'(C_ADD));
    check("trig_count",      32'(retired_count), 32'(9));
    tick();
    check("trig_add_count",  32'(retired_count), 32'(10));
    check("trig_add_empty",  32'(out_valid), 32'(0));

    // Flush while in TRIG_BUSY: instruction dropped, nothing retires.
    drive(1'b1, C_SIN, 4'h0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    check("tflush_ready", 32'(in_ready), 32'(0));
    tick();
    flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("tflush_empty%0d", k), 32'(out_valid), 32'(0));
      tick();
    end
    check("tflush_count",    32'(retired_count), 32'(10));
    check("tflush_flags",    32'(flags), 32'(8));
    check("tflush_redirect", 32'(redirect), 32'(0));

    // Counter wrap with CNT_W=4: 17 NOPs give a count of 1.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    check("wrap_start", 32'(retired_count), 32'(0));
    tick();
    drive(1'b1, C_NOP, 4'h0, 1'b0, 1'b1);
    for (int k = 0; k < 17; k++) tick();
    check("wrap_16", 32'(retired_count), 32'(0));
    in_valid = 1'b0;
    tick();
    check("wrap_17", 32'(retired_count), 32'(1));

    // Async reset mid-HOLD with non-zero flags and count.
    drive(1'b1, C_CMP, 4'h9, 1'b0, 1'b1);
    tick();
    in_ctrl = C_ADD;
    tick();
    drive(1'b0, C_NOP, 4'h0, 1'b0, 1'b0);
    tick();
    check("pre_rst_valid", 32'(out_valid), 32'(1));
    check("pre_rst_flags", 32'(flags), 32'(9));
    check("pre_rst_count", 32'(retired_count), 32'(2));
    #1;
    rst = 1'b1;
    #1;
    check("arst_valid",    32'(out_valid), 32'(0));
    check("arst_ctrl",     32'(out_ctrl), 32'(0));
    check("arst_flags",    32'(flags), 32'(0));
    check("arst_redirect", 32'(redirect), 32'(0));
    check("arst_link",     32'(link_write), 32'(0));
    check("arst_count",    32'(retired_count), 32'(0));
    rst = 1'b0;
    tick();
    check("post_rst_valid", 32'(out_valid), 32'(0));
    check("post_rst_ready", 32'(in_ready), 32'(1));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/deco_exe_ctrl_stage.md
Name: deco_exe_ctrl_stage

Overview:
- Receiving end of the decode-to-execute control bundle that the control-unit tasks produce (pcSrc, regWrite, trigControl, aluControl, memToReg, flagWrite, immSrc, aluSrc, memWrite, memPixWrite, branch).
- Registers one instruction's control word with a valid/ready handshake.
- Stalls for multi-cycle SIN/COS operations (trigControl=1).
- Holds the NZCV flag register, commits branch redirects and counts retired instructions.
- Sits between the decode stage and the memory-stage pipeline register.

Parameters:
TRIG_LATENCY, 4, execute cycles for a trigControl=1 instruction (min 1; 1 means no extra stall)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  decode presents a control word
in_ready  output  1  stage can accept this cycle
in_ctrl  input  16  {pcSrc, regWrite, trigControl, aluControl[3:0], memToReg[1:0], flagWrite, immSrc, aluSrc, memWrite, memPixWrite, branch, bLink}
alu_flags  input  4  N,Z,C,V from the ALU for the held instruction
flush  input  1  kill the held instruction (hazard/exception)
out_valid  output  1  held instruction complete, presented to memory stage
out_ready  input  1  memory stage accepts
out_ctrl  output  16  held control word, same packing as in_ctrl
flags  output  4  committed NZCV register
redirect  output  1  one-cycle pulse: taken branch retired
link_write  output  1  one-cycle pulse with redirect when bLink=1
retired_count  output  CNT_W  instructions retired, wraps

Behaviour:
- Reset (async, any state): state=EMPTY, out_valid=0, out_ctrl=0, flags=0000, redirect=0, link_write=0, retired_count=0, trig counter=0.
- The same reset applies mid-TRIG_BUSY: the held instruction is lost and no flag write or count happens.
- States:
  - EMPTY: in_ready=1. in_valid captures in_ctrl. Next state is TRIG_BUSY if trigControl=1 and TRIG_LATENCY>1, else HOLD.
  - TRIG_BUSY: counter loaded with TRIG_LATENCY-2 on capture and decremented each cycle. out_valid=0, in_ready=0. At 0 go to HOLD.
  - HOLD: out_valid=1.
- Fire = out_valid & out_ready.
- In HOLD, in_ready = out_ready, so a new capture can happen in the same cycle as fire (back-to-back: one instruction per cycle when no trig stall).
- On fire:
  - If flagWrite=1, flags <= alu_flags sampled that cycle.
  - retired_count += 1, wrapping from 2^CNT_W-1 to 0.
  - If branch=1 and pcSrc=1: redirect=1 next cycle for exactly one cycle, and link_write=bLink.
  - The instruction captured in the same cycle as a redirecting fire is squashed: state goes to EMPTY and it is neither counted nor presented.
- Flush (priority over everything):
  - Drops the held instruction; state <= EMPTY next cycle.
  - No flag write, no count, no redirect.
  - in_ready=0 during a flush cycle, so no capture happens.
- Flush with fire in the same cycle: flush wins and the instruction does not retire.
- NOP (regWrite=0, all control 0) is a normal instruction: it retires and counts.
- in_ctrl is sampled only on capture. out_ctrl is stable while out_valid=1 and out_ready=0.
- alu_flags is don't-care except in fire cycles.
- No combinational path from in_valid to out_valid. Latency capture→out_valid: 1 cycle (non-trig), TRIG_LATENCY cycles (trig).

Test Plan:
- Reset, then an ADD word (regWrite=1, aluControl=0010, memToReg=01) with out_ready=1 → out_valid on cycle 1, out_ctrl equals input, retired_count=1, flags=0000.
- CMP (flagWrite=1, aluControl=0001) with alu_flags=0100 at fire, then back-to-back ADD, out_ready held 1 → flags=0100 after CMP fire, unchanged after ADD, one retire per cycle, count=2.
- SIN (trigControl=1), TRIG_LATENCY=4, with in_valid held → in_ready=0 for 3 cycles, out_valid rises on cycle 4; the next word is captured on the fire cycle.
- BL word (branch=1, pcSrc=1, bLink=1) fires while the next word is offered → redirect=1 and link_write=1 for exactly one cycle, the next word is squashed, retired_count increments by 1 only.
- Flush asserted during TRIG_BUSY and again coincident with a CMP fire → state EMPTY, flags and retired_count unchanged, no redirect.
- CNT_W=4, retire 17 NOPs → retired_count=1; async rst asserted mid-HOLD → all outputs 0 immediately, without waiting for a clk edge.
